// File: rtl/conv3_pkg.sv
// Shared definitions for the conv3 window scheduler: FSM encodings,
// default geometry, and the derived window count.
package conv3_pkg;

    localparam int DEF_LENGTH     = 11;
    localparam int DEF_HEIGHT     = 11;
    localparam int DEF_FILTER     = 3;
    localparam int DEF_STRIDE     = 1;
    localparam int DEF_MEM_LENGTH = 11;
    localparam int DEF_MEM_HEIGHT = 4;

    localparam int WINDOWS = ((DEF_LENGTH - DEF_FILTER) / DEF_STRIDE + 1) *
                             ((DEF_HEIGHT - DEF_FILTER) / DEF_STRIDE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        R_WAIT  = 2'd0,
        R_FETCH = 2'd1,
        R_END   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/conv_window_sched_ring_slot_add.sv
// Modulo-MEM_HEIGHT adder for ring-buffer slot indices.
// Both operands must already be below MEM_HEIGHT, so one conditional subtract suffices.
module ring_slot_add #(
    parameter int MEM_HEIGHT = 4,
    parameter int SLOT_W     = 2
) (
    input  logic [SLOT_W-1:0] a,
    input  logic [SLOT_W-1:0] b,
    output logic [SLOT_W-1:0] sum
);

    logic [SLOT_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        if (raw >= (SLOT_W+1)'(MEM_HEIGHT)) begin
            sum = SLOT_W'(raw - (SLOT_W+1)'(MEM_HEIGHT));
        end else begin
            sum = raw[SLOT_W-1:0];
        end
    end

endmodule

// File: rtl/conv_window_sched.sv
// Row ring-buffer scheduler for conv3: writes the raster stream, reads every
// FILTER x FILTER window tap by tap. Optional stall counter: CONV_WIN_SCHED_PERF_EN.
module conv_window_sched
    import conv3_pkg::*;
#(
    parameter int LENGTH     = DEF_LENGTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int FILTER     = DEF_FILTER,
    parameter int STRIDE     = DEF_STRIDE,
    parameter int MEM_LENGTH = DEF_MEM_LENGTH,
    parameter int MEM_HEIGHT = DEF_MEM_HEIGHT,
    parameter int LEN_W      = 4,
    parameter int HGT_W      = 4,
    parameter int ADDR_W     = 6
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              win_ready,
    output logic              win_valid,
    output logic              win_first,
    output logic              win_last,
    output logic              busy,
    output logic              frame_done
`ifdef CONV_WIN_SCHED_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int SLOT_W = (MEM_HEIGHT > 1) ? $clog2(MEM_HEIGHT) : 1;
    localparam int TAP_W  = (FILTER > 1) ? $clog2(FILTER) : 1;

    top_state_t        state;
    rd_state_t         r_state;
    logic [HGT_W-1:0]  wr_row, rows_done, top_row;
    logic [LEN_W-1:0]  wr_col, left_col;
    logic [SLOT_W-1:0] wr_slot, wr_slot_next, top_slot, top_slot_next, rd_slot;
    logic [TAP_W-1:0]  kx, ky;
    logic              wr_done;
    logic              tap_last, col_wrap, frame_end, win_go;

    ring_slot_add #(.MEM_HEIGHT(MEM_HEIGHT), .SLOT_W(SLOT_W)) u_wr_slot (
        .a(wr_slot), .b(SLOT_W'(1)), .sum(wr_slot_next)
    );
    ring_slot_add #(.MEM_HEIGHT(MEM_HEIGHT), .SLOT_W(SLOT_W)) u_top_slot (
        .a(top_slot), .b(SLOT_W'(STRIDE)), .sum(top_slot_next)
    );
    ring_slot_add #(.MEM_HEIGHT(MEM_HEIGHT), .SLOT_W(SLOT_W)) u_rd_slot (
        .a(top_slot), .b(SLOT_W'(ky)), .sum(rd_slot)
    );

    // NOTE: every signal gets a value on every pass, so no latch is inferred.
    always_comb begin
        // The writer may run at most MEM_HEIGHT rows ahead of the oldest row still in use.
        pix_ready  = (state == RUN) && !wr_done && (int'(wr_row) < int'(top_row) + MEM_HEIGHT);
        wr_en      = pix_valid && pix_ready;
        wr_addr    = ADDR_W'(wr_slot) * ADDR_W'(MEM_LENGTH) + ADDR_W'(wr_col);
        rd_addr    = ADDR_W'(rd_slot) * ADDR_W'(MEM_LENGTH) + ADDR_W'(left_col) + ADDR_W'(kx);
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        tap_last   = (kx == TAP_W'(FILTER-1)) && (ky == TAP_W'(FILTER-1));
        col_wrap   = int'(left_col) > LENGTH - FILTER - STRIDE;
        frame_end  = int'(top_row) > HEIGHT - FILTER - STRIDE;
        win_go     = (int'(rows_done) >= int'(top_row) + FILTER) && win_ready;
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            r_state   <= R_WAIT;
            wr_row    <= '0;
            wr_col    <= '0;
            wr_slot   <= '0;
            wr_done   <= 1'b0;
            rows_done <= '0;
            top_row   <= '0;
            top_slot  <= '0;
            left_col  <= '0;
            kx        <= '0;
            ky        <= '0;
            win_valid <= 1'b0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        r_state   <= R_WAIT;
                        wr_row    <= '0;
                        wr_col    <= '0;
                        wr_slot   <= '0;
                        wr_done   <= 1'b0;
                        rows_done <= '0;
                        top_row   <= '0;
                        top_slot  <= '0;
                        left_col  <= '0;
                        kx        <= '0;
                        ky        <= '0;
                    end
                end
                RUN: begin
                    if (r_state == R_END) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (wr_en) begin
                if (wr_col == LEN_W'(LENGTH-1)) begin
                    wr_col    <= '0;
                    wr_slot   <= wr_slot_next;
                    rows_done <= rows_done + 1'b1;
                    if (wr_row == HGT_W'(HEIGHT-1)) wr_done <= 1'b1;
                    else                            wr_row  <= wr_row + 1'b1;
                end else begin
                    wr_col <= wr_col + 1'b1;
                end
            end

            // Flags follow the fetch cycle by one so they line up with RAM doutb.
            win_valid <= (r_state == R_FETCH);
            win_first <= (r_state == R_FETCH) && (kx == '0) && (ky == '0);
            win_last  <= (r_state == R_FETCH) && tap_last;

            if (state == RUN) begin
                case (r_state)
                    R_WAIT: begin
                        if (win_go) r_state <= R_FETCH;
                    end
                    R_FETCH: begin
                        if (ky == TAP_W'(FILTER-1)) begin
                            ky <= '0;
                            if (kx == TAP_W'(FILTER-1)) begin
                                kx <= '0;
                                if (col_wrap) begin
                                    left_col <= '0;
                                    if (frame_end) begin
                                        r_state <= R_END;
                                    end else begin
                                        top_row  <= top_row + HGT_W'(STRIDE);
                                        top_slot <= top_slot_next;
                                        r_state  <= R_WAIT;
                                    end
                                end else begin
                                    left_col <= left_col + LEN_W'(STRIDE);
                                    r_state  <= R_WAIT;
                                end
                            end else begin
                                kx <= kx + 1'b1;
                            end
                        end else begin
                            ky <= ky + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CONV_WIN_SCHED_PERF_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RUN && pix_valid && !pix_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench for conv_window_sched: a behavioural dual-port RAM plus a
// scoreboard of expected taps (pixel id, address, first/last) built per frame.
`timescale 1ns/1ps
module tb_conv_window_sched;
    import conv3_pkg::*;

    localparam int L  = DEF_LENGTH;
    localparam int H  = DEF_HEIGHT;
    localparam int F  = DEF_FILTER;
    localparam int S  = DEF_STRIDE;
    localparam int ML = DEF_MEM_LENGTH;
    localparam int MH = DEF_MEM_HEIGHT;
    localparam int AW = 6;
    localparam int TAPS = WINDOWS * F * F;

    logic          clk_in = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          win_ready = 1'b0;
    logic          pix_ready, wr_en, win_valid, win_first, win_last, busy, frame_done;
    logic [AW-1:0] wr_addr, rd_addr;
`ifdef CONV_WIN_SCHED_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    typedef struct {
        int id;
        int addr;
        bit first;
        bit last;
    } tap_t;

    tap_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mem [0:(1<<AW)-1];
    int   rd_data = 0, rd_addr_q = 0, wr_cnt = 0, cyc = 0;
    int   n_wr = 0, n_valid = 0, n_first = 0, n_last = 0, n_done = 0;
    int   last_wl_cyc = 0, first_cyc = 0;

    always #5 clk_in = ~clk_in;

    conv_window_sched dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .win_ready (win_ready),
        .win_valid (win_valid),
        .win_first (win_first),
        .win_last  (win_last),
        .busy      (busy),
        .frame_done(frame_done)
`ifdef CONV_WIN_SCHED_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // RAM model: pixel value = arrival index of the write in the frame.
    always @(posedge clk_in) begin
        cyc       <= cyc + 1;
        rd_data   <= mem[rd_addr];
        rd_addr_q <= int'(rd_addr);
        if (start && !busy) wr_cnt <= 0;
        else if (wr_en) begin
            mem[wr_addr] <= wr_cnt;
            wr_cnt       <= wr_cnt + 1;
        end
    end

    always @(negedge clk_in) begin
        if (wr_en) n_wr++;
        if (frame_done) begin
            n_done++;
            check("done_after_last", cyc - last_wl_cyc, 1);
        end
        if (win_valid) begin
            n_valid++;
            if (win_first) begin
                n_first++;
                first_cyc = cyc;
            end
            if (win_last) begin
                n_last++;
                last_wl_cyc = cyc;
                check("win_contig", cyc - first_cyc, F*F - 1);
            end
            if (exp_q.size() == 0) begin
                check("tap_queued", exp_q.size(), 1);
            end else begin
                tap_t e;
                e = exp_q.pop_front();
                check("tap_data", rd_data, e.id);
                check("tap_addr", rd_addr_q, e.addr);
                check("tap_first", win_first, e.first);
                check("tap_last", win_last, e.last);
            end
        end
    end

    task automatic push_frame();
        exp_q.delete();
        for (int t = 0; t <= H - F; t += S)
            for (int l = 0; l <= L - F; l += S)
                for (int kx = 0; kx < F; kx++)
                    for (int ky = 0; ky < F; ky++) begin
                        tap_t e;
                        e.id    = (t + ky) * L + l + kx;
                        e.addr  = ((t + ky) % MH) * ML + l + kx;
                        e.first = (kx == 0) && (ky == 0);
                        e.last  = (kx == F - 1) && (ky == F - 1);
                        exp_q.push_back(e);
                    end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge clk_in); #1;
            k++;
        end while (frame_done !== 1'b1 && k < budget);
        check("frame_done_seen", frame_done, 1);
        check("busy_in_done", busy, 1);
        @(negedge clk_in); #1;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", frame_done, 0);
    endtask

    task automatic check_frame(input string tag, input int b_wr, input int b_first,
                               input int b_last, input int b_valid, input int b_done);
        check({tag, "_writes"}, n_wr - b_wr, L * H);
        check({tag, "_firsts"}, n_first - b_first, WINDOWS);
        check({tag, "_lasts"},  n_last - b_last, WINDOWS);
        check({tag, "_taps"},   n_valid - b_valid, TAPS);
        check({tag, "_dones"},  n_done - b_done, 1);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int b_wr, b_first, b_last, b_valid, b_done, k;

        #1 rst = 1'b1;
        #10;
        check("rst_pix_ready", pix_ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_first", win_first, 0);
        check("rst_win_last", win_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_rd_addr", rd_addr, 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Abort a frame after 20 pixels.
        push_frame();
        pulse_start();
        pix_valid = 1'b1;
        win_ready = 1'b1;
        b_wr = n_wr;
        k = 0;
        while (n_wr - b_wr < 20 && k < 200) begin
            @(negedge clk_in); #1;
            k++;
        end
        check("abort_20_pixels", n_wr - b_wr, 20);
        rst = 1'b1;
        #1;
        check("abort_wr_en", wr_en, 0);
        check("abort_pix_ready", pix_ready, 0);
        check("abort_win_valid", win_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        b_done = n_done;
        tick(2);
        rst = 1'b0;
        pix_valid = 1'b0;
        tick(5);
        check("abort_no_done", n_done - b_done, 0);

        // Full frame after restart; a start pulse mid-frame must be ignored.
        push_frame();
        pulse_start();
        check("restart_wr_addr", wr_addr, 0);
        check("restart_busy", busy, 1);
        check("restart_pix_ready", pix_ready, 1);
        b_wr = n_wr; b_first = n_first; b_last = n_last; b_valid = n_valid; b_done = n_done;
        pix_valid = 1'b1;
        win_ready = 1'b1;
        tick(200);
        pulse_start();
        check("start_ignored_busy", busy, 1);
        wait_done(3000);
        tick(1);
        check_frame("full", b_wr, b_first, b_last, b_valid, b_done);

        // Reader blocked: the writer must stop after MEM_HEIGHT rows.
        pix_valid = 1'b0;
        win_ready = 1'b0;
        push_frame();
        pulse_start();
        b_wr = n_wr; b_first = n_first; b_last = n_last; b_valid = n_valid; b_done = n_done;
        pix_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk_in); #1;
            k++;
        end while (pix_ready === 1'b1 && k < 200);
        check("bp_ready_low", pix_ready, 0);
`ifdef CONV_WIN_SCHED_PERF_EN
        check("stall_cnt_zero", stall_cnt, 0);
`endif
        repeat (10) @(negedge clk_in);
        #1;
`ifdef CONV_WIN_SCHED_PERF_EN
        check("stall_cnt_10", stall_cnt, 10);
`endif
        tick(40);
        check("bp_writes", n_wr - b_wr, MH * L);
        check("bp_still_blocked", pix_ready, 0);
        check("bp_no_taps", n_valid - b_valid, 0);
        win_ready = 1'b1;
        wait_done(3000);
        tick(1);
        check_frame("bp", b_wr, b_first, b_last, b_valid, b_done);

        // Drop win_ready mid-window: that window completes, the next one waits.
        pix_valid = 1'b0;
        push_frame();
        pulse_start();
        b_wr = n_wr; b_first = n_first; b_last = n_last; b_valid = n_valid; b_done = n_done;
        pix_valid = 1'b1;
        win_ready = 1'b1;
        k = 0;
        while (n_first - b_first < 1 && k < 500) begin
            @(negedge clk_in); #1;
            k++;
        end
        check("drop_first_seen", n_first - b_first, 1);
        tick(3);
        win_ready = 1'b0;
        tick(40);
        check("drop_one_window_first", n_first - b_first, 1);
        check("drop_one_window_last", n_last - b_last, 1);
        check("drop_nine_taps", n_valid - b_valid, F * F);
        win_ready = 1'b1;
        wait_done(3000);
        tick(1);
        check_frame("drop", b_wr, b_first, b_last, b_valid, b_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
